// File: rtl/ram_dp.sv
// Single-clock simple dual-port RAM with byte enables, 1- or 2-cycle read latency,
// selectable collision policy and an optional zero-fill sweep after reset.
module ram_dp #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int RD_LATENCY     = 1,
    parameter int WRITE_FIRST    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    collision
);
    // state    | meaning
    // ST_CLEAR | zero-fill sweep over mem[clr_cnt], requests ignored
    // ST_RUN   | normal read/write operation

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    rd_fire;
    logic                    rd_coll;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_CLEAR: begin
                clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                if (&clr_cnt) begin
                    state_nxt   = ST_RUN;
                    clr_cnt_nxt = '0;
                end
            end
            ST_RUN: ;
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign busy    = (state == ST_CLEAR);
    assign rd_fire = (state == ST_RUN) && rd_en;
    assign rd_coll = wr_en && rd_en && (wr_addr == rd_addr);

    // The array itself is never reset; it is only touched on non-reset edges.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write-first bypass merges only the enabled byte lanes into the old word.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((WRITE_FIRST != 0) && rd_coll) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  s1_valid;
            logic                  s1_coll;
            logic [DATA_WIDTH-1:0] s1_data;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid  <= 1'b0;
                    s1_coll   <= 1'b0;
                    s1_data   <= '0;
                    rd_valid  <= 1'b0;
                    collision <= 1'b0;
                    rd_data   <= '0;
                end else begin
                    s1_valid  <= rd_fire;
                    s1_coll   <= rd_fire && rd_coll;
                    if (rd_fire) s1_data <= rd_word;
                    rd_valid  <= s1_valid;
                    collision <= s1_coll;
                    if (s1_valid) rd_data <= s1_data;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_valid  <= 1'b0;
                    collision <= 1'b0;
                    rd_data   <= '0;
                end else begin
                    rd_valid  <= rd_fire;
                    collision <= rd_fire && rd_coll;
                    if (rd_fire) rd_data <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: four instances (default, read-first, 2-cycle latency,
// no clear on reset) share one stimulus stream.
module tb_ram_dp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;

    logic [15:0] rd_data0, rd_data1, rd_data2, rd_data3;
    logic        rd_valid0, rd_valid1, rd_valid2, rd_valid3;
    logic        busy0, busy1, busy2, busy3;
    logic        coll0, coll1, coll2, coll3;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ram_dp #(.WRITE_FIRST(1)) d0 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0), .collision(coll0));
    ram_dp #(.WRITE_FIRST(0)) d1 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .collision(coll1));
    ram_dp #(.RD_LATENCY(2)) d2 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .collision(coll2));
    ram_dp #(.CLEAR_ON_RESET(0)) d3 (.clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .busy(busy3), .collision(coll3));

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic        ev;
        logic [15:0] ed0;
        logic [15:0] ed1;
        logic        ec;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = 2'b00;
    endtask

    // Steps until d0 leaves the sweep, checking nothing is returned meanwhile.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy0 && n < 40) begin
            step();
            n++;
            chk("busy_quiet0", {31'd0, rd_valid0 | coll0}, 32'd0);
            chk("busy_quiet1", {31'd0, rd_valid1 | coll1}, 32'd0);
        end
    endtask

    initial begin
        int n;

        tbl[0]  = '{1'b1, 4'd3, 16'h1234, 2'b11, 1'b0, 4'd0,  1'b0, 16'h0F0F, 16'h0F0F, 1'b0};
        tbl[1]  = '{1'b1, 4'd3, 16'hABCD, 2'b01, 1'b0, 4'd0,  1'b0, 16'h0F0F, 16'h0F0F, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3,  1'b1, 16'h12CD, 16'h12CD, 1'b0};
        tbl[3]  = '{1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0,  1'b0, 16'h12CD, 16'h12CD, 1'b0};
        tbl[4]  = '{1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5,  1'b1, 16'h2222, 16'h1111, 1'b1};
        tbl[5]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5,  1'b1, 16'h2222, 16'h2222, 1'b0};
        tbl[6]  = '{1'b1, 4'd6, 16'hBEEF, 2'b10, 1'b1, 4'd6,  1'b1, 16'hBE06, 16'h0606, 1'b1};
        tbl[7]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd6,  1'b1, 16'hBE06, 16'hBE06, 1'b0};
        tbl[8]  = '{1'b1, 4'd7, 16'h5555, 2'b00, 1'b1, 4'd7,  1'b1, 16'h0707, 16'h0707, 1'b1};
        tbl[9]  = '{1'b1, 4'd8, 16'hAAAA, 2'b11, 1'b1, 4'd9,  1'b1, 16'h0909, 16'h0909, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0,  1'b0, 16'h0909, 16'h0909, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd8,  1'b1, 16'hAAAA, 16'hAAAA, 1'b0};
        tbl[12] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0,  1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[13] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd15, 1'b1, 16'h0F0F, 16'h0F0F, 1'b0};

        // Reset state
        step();
        step();
        chk("rst_busy0", {31'd0, busy0}, 32'd1);
        chk("rst_valid0", {31'd0, rd_valid0}, 32'd0);
        chk("rst_data0", {16'd0, rd_data0}, 32'd0);
        chk("rst_busy3", {31'd0, busy3}, 32'd0);

        // Initial sweep is exactly 16 edges
        rst_n = 1'b1;
        wait_busy(n);
        chk("sweep_len", n, 32'd16);

        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            rd_addr = 4'(i);
            step();
            chk("clr_valid", {31'd0, rd_valid0}, 32'd1);
            chk("clr_data", {16'd0, rd_data0}, 32'd0);
        end
        idle();

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_addr = 4'(i);
            wr_data = 16'(16'h0101 * i);
            wr_be = 2'b11;
            step();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            rd_addr = 4'(i);
            step();
            chk("b2b_valid", {31'd0, rd_valid0}, 32'd1);
            chk("b2b_data", {16'd0, rd_data0}, 32'(16'h0101 * i));
        end
        idle();
        step();
        chk("hold_valid", {31'd0, rd_valid0}, 32'd0);
        chk("hold_data", {16'd0, rd_data0}, 32'h0F0F);

        for (int i = 0; i < 14; i++) begin
            wr_en = tbl[i].we;
            wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd;
            wr_be = tbl[i].be;
            rd_en = tbl[i].re;
            rd_addr = tbl[i].ra;
            step();
            chk($sformatf("tbl%0d_valid", i), {31'd0, rd_valid0}, {31'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_data_wf", i), {16'd0, rd_data0}, {16'd0, tbl[i].ed0});
            chk($sformatf("tbl%0d_data_rf", i), {16'd0, rd_data1}, {16'd0, tbl[i].ed1});
            chk($sformatf("tbl%0d_coll_wf", i), {31'd0, coll0}, {31'd0, tbl[i].ec});
            chk($sformatf("tbl%0d_coll_rf", i), {31'd0, coll1}, {31'd0, tbl[i].ec});
        end
        idle();
        step();
        step();

        // Two-cycle latency pipeline
        rd_en = 1'b1;
        rd_addr = 4'd3;
        step();
        chk("lat2_n_valid", {31'd0, rd_valid2}, 32'd0);
        rd_addr = 4'd8;
        step();
        chk("lat2_n1_valid", {31'd0, rd_valid2}, 32'd1);
        chk("lat2_n1_data", {16'd0, rd_data2}, 32'h12CD);
        idle();
        step();
        chk("lat2_n2_valid", {31'd0, rd_valid2}, 32'd1);
        chk("lat2_n2_data", {16'd0, rd_data2}, 32'hAAAA);
        step();
        chk("lat2_n3_valid", {31'd0, rd_valid2}, 32'd0);
        chk("lat2_n3_hold", {16'd0, rd_data2}, 32'hAAAA);

        // Reset in flight drops the pending latency-2 read
        rd_en = 1'b1;
        rd_addr = 4'd5;
        step();
        chk("lat2_rst_pre", {31'd0, rd_valid2}, 32'd0);
        idle();
        rst_n = 1'b0;
        step();
        chk("lat2_rst_valid", {31'd0, rd_valid2}, 32'd0);
        chk("rst_data_zero0", {16'd0, rd_data0}, 32'd0);
        chk("rst_busy_again", {31'd0, busy0}, 32'd1);
        chk("rst_busy_noclr", {31'd0, busy3}, 32'd0);
        step();
        chk("lat2_rst_valid2", {31'd0, rd_valid2}, 32'd0);

        // Contents survive reset without the clear sweep
        rst_n = 1'b1;
        rd_en = 1'b1;
        rd_addr = 4'd7;
        step();
        chk("retain_valid", {31'd0, rd_valid3}, 32'd1);
        chk("retain_data", {16'd0, rd_data3}, 32'h0707);
        chk("retain_busy_ignore", {31'd0, rd_valid0}, 32'd0);
        idle();
        wait_busy(n);
        chk("sweep2_len", n + 1, 32'd16);

        // Reset at sweep edge 7 restarts the full sweep; requests meanwhile are dropped
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("mid_busy", {31'd0, busy0}, 32'd1);
        end
        rst_n = 1'b0;
        step();
        chk("mid_rst_busy", {31'd0, busy0}, 32'd1);
        rst_n = 1'b1;
        wr_en = 1'b1;
        wr_addr = 4'd2;
        wr_data = 16'hFFFF;
        wr_be = 2'b11;
        rd_en = 1'b1;
        rd_addr = 4'd2;
        wait_busy(n);
        chk("restart_len", n, 32'd16);
        idle();
        rd_en = 1'b1;
        rd_addr = 4'd2;
        step();
        chk("after_busy_valid", {31'd0, rd_valid0}, 32'd1);
        chk("after_busy_data", {16'd0, rd_data0}, 32'd0);
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
